// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: default sizes,
// request opcodes, controller states and a small opcode-decode helper.
package dm_pkg;

    localparam int AW_DEF   = 8;
    localparam int DW_DEF   = 16;
    localparam int NREG_DEF = 8;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LW   = 3'd1,
        OP_SW   = 3'd2,
        OP_LM   = 3'd3,
        OP_SM   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_MULTI  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // True for the four opcodes that start a memory operation; codes 5..7
    // behave like NONE and are never accepted.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/mask_pri_enc.sv
// Lowest-set-bit priority encoder for the LM/SM register mask. Returns the
// index of the lowest set bit and flags an all-zero mask.
module mask_pri_enc #(
    parameter  int NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic [NREG-1:0] mask,
    output logic [RW-1:0]   idx,
    output logic            none
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int j = NREG - 1; j >= 0; j--) begin
            if (mask[j]) begin
                idx = RW'(j);
            end
        end
    end

    assign none = ~|mask;

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory initiator. Sequences LW/SW as a single access and
// LM/SM as one access per selected register, then signals completion for
// one cycle in DONE. The pipeline is stalled (busy) whenever not IDLE.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter  int AW   = AW_DEF,
    parameter  int DW   = DW_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int RW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [NREG-1:0] req_mask,
    output logic            busy,
    output logic [AW-1:0]   dm_addr,
    output logic            dm_read,
    output logic            dm_write,
    output logic [DW-1:0]   dm_wdata,
    input  logic [DW-1:0]   dm_rdata,
    output logic [RW-1:0]   rf_raddr,
    input  logic [DW-1:0]   rf_rdata,
    output logic            rf_we,
    output logic [RW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic            ld_valid,
    output logic [DW-1:0]   ld_data,
    output logic            op_done
);

    state_e          state_reg, state_next;
    op_e             op_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [NREG-1:0] mask_reg;
    logic [NREG-1:0] mask_next;
    logic [AW-1:0]   k_reg;
    logic [DW-1:0]   ld_data_reg;

    logic [RW-1:0]   cur_idx;
    logic            mask_none;
    logic            accept;

    mask_pri_enc #(.NREG(NREG)) u_pri_enc (
        .mask (mask_reg),
        .idx  (cur_idx),
        .none (mask_none)
    );

    assign accept  = (state_reg == S_IDLE) && req_valid && is_mem_op(req_op);
    assign ld_data = ld_data_reg;

    // Remaining mask after retiring the register serviced this cycle.
    always_comb begin
        mask_next          = mask_reg;
        mask_next[cur_idx] = 1'b0;
    end

    // Next-state logic and all strobes; everything idles at zero by default.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        busy       = 1'b1;
        dm_addr    = '0;
        dm_read    = 1'b0;
        dm_write   = 1'b0;
        dm_wdata   = '0;
        rf_raddr   = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        ld_valid   = 1'b0;
        op_done    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    if (req_op == OP_LW || req_op == OP_SW) begin
                        state_next = S_SINGLE;
                    end else if (req_mask == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_MULTI;
                    end
                end
            end
            S_SINGLE: begin
                dm_addr = addr_reg;
                if (op_reg == OP_LW) begin
                    dm_read = 1'b1;
                end else begin
                    dm_write = 1'b1;
                    dm_wdata = wdata_reg;
                end
                state_next = S_DONE;
            end
            S_MULTI: begin
                if (mask_none) begin
                    state_next = S_DONE;
                end else begin
                    dm_addr = addr_reg + k_reg;
                    if (op_reg == OP_LM) begin
                        dm_read  = 1'b1;
                        rf_we    = 1'b1;
                        rf_waddr = cur_idx;
                        rf_wdata = dm_rdata;
                    end else begin
                        rf_raddr = cur_idx;
                        dm_write = 1'b1;
                        dm_wdata = rf_rdata;
                    end
                    if (mask_next == '0) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                op_done    = 1'b1;
                ld_valid   = (op_reg == OP_LW);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, request latch, multi-access progress and the LW result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            op_reg      <= OP_NONE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            mask_reg    <= '0;
            k_reg       <= '0;
            ld_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg    <= op_e'(req_op);
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                mask_reg  <= req_mask;
                k_reg     <= '0;
            end
            if (state_reg == S_MULTI && !mask_none) begin
                mask_reg <= mask_next;
                k_reg    <= k_reg + 1'b1;
            end
            if (state_reg == S_SINGLE && op_reg == OP_LW) begin
                ld_data_reg <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with behavioural data
// memory and register file models driven by the DUT strobes.
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  req_mask;
    logic        busy;
    logic [7:0]  dm_addr;
    logic        dm_read;
    logic        dm_write;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        op_done;

    logic [15:0] dm_mem [256];
    logic [15:0] rf_mem [8];

    logic        tb_dm_we;
    logic [7:0]  tb_dm_addr;
    logic [15:0] tb_dm_data;
    logic        tb_rf_we;
    logic [2:0]  tb_rf_addr;
    logic [15:0] tb_rf_data;

    int n_checks;
    int n_fail;

    dm_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .busy      (busy),
        .dm_addr   (dm_addr),
        .dm_read   (dm_read),
        .dm_write  (dm_write),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .op_done   (op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: combinational reads, writes at the rising edge.
    assign dm_rdata = dm_read ? dm_mem[dm_addr] : 16'h0000;
    assign rf_rdata = rf_mem[rf_raddr];

    always @(posedge clk) begin
        if (dm_write) dm_mem[dm_addr] <= dm_wdata;
        else if (tb_dm_we) dm_mem[tb_dm_addr] <= tb_dm_data;
    end

    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        else if (tb_rf_we) rf_mem[tb_rf_addr] <= tb_rf_data;
    end

    task automatic dm_poke(input logic [7:0] a, input logic [15:0] d);
        tb_dm_we = 1'b1; tb_dm_addr = a; tb_dm_data = d;
        @(posedge clk); #1;
        tb_dm_we = 1'b0;
    endtask

    task automatic rf_poke(input logic [2:0] a, input logic [15:0] d);
        tb_rf_we = 1'b1; tb_rf_addr = a; tb_rf_data = d;
        @(posedge clk); #1;
        tb_rf_we = 1'b0;
    endtask

    // Present a request for one edge; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a,
                         input logic [15:0] wd, input logic [7:0] m);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_mask = m;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        $display("tx op=%0d addr=%02h wdata=%04h mask=%02h", op, a, wd, m);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b exp 1", req_ready);
        end
        n_checks++;
        if ({busy, dm_read, dm_write, rf_we, ld_valid, op_done} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b exp 000000",
                               {busy, dm_read, dm_write, rf_we, ld_valid, op_done});
        end
        n_checks++;
        if ({dm_addr, dm_wdata, rf_raddr, rf_waddr, rf_wdata, ld_data} !== 62'h0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wdata=%h ld=%h exp 0",
                               dm_addr, dm_wdata, ld_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw;
        dm_poke(8'h10, 16'h1234);
        @(negedge clk);
        issue(3'd1, 8'h10, 16'h0, 8'h0);
        @(negedge clk);
        n_checks++;
        if ({dm_read, dm_write, busy} !== 3'b101 || dm_addr !== 8'h10) begin
            n_fail++; $display("FAIL lw_access: rd=%b wr=%b busy=%b addr=%h exp 1 0 1 10",
                               dm_read, dm_write, busy, dm_addr);
        end
        n_checks++;
        if (ld_valid !== 1'b0 || op_done !== 1'b0) begin
            n_fail++; $display("FAIL lw_early: ld_valid=%b op_done=%b exp 0 0", ld_valid, op_done);
        end
        @(negedge clk);
        n_checks++;
        if ({ld_valid, op_done, dm_read} !== 3'b110 || ld_data !== 16'h1234) begin
            n_fail++; $display("FAIL lw_result: ld_valid=%b op_done=%b rd=%b ld_data=%h exp 1 1 0 1234",
                               ld_valid, op_done, dm_read, ld_data);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, req_ready, ld_valid} !== 3'b010 || ld_data !== 16'h1234) begin
            n_fail++; $display("FAIL lw_idle: busy=%b ready=%b ld_valid=%b ld_data=%h exp 0 1 0 1234",
                               busy, req_ready, ld_valid, ld_data);
        end
    endtask

    task automatic test_sw;
        int wr_cnt;
        int busy_cnt;
        wr_cnt = 0;
        busy_cnt = 0;
        issue(3'd2, 8'h20, 16'hBEEF, 8'h0);
        @(negedge clk);
        n_checks++;
        if (dm_write !== 1'b1 || dm_read !== 1'b0 || dm_addr !== 8'h20 || dm_wdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL sw_access: wr=%b rd=%b addr=%h wdata=%h exp 1 0 20 BEEF",
                               dm_write, dm_read, dm_addr, dm_wdata);
        end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (dm_write === 1'b1) wr_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (c == 1) begin
                n_checks++;
                if (op_done !== 1'b1 || ld_valid !== 1'b0) begin
                    n_fail++; $display("FAIL sw_done: op_done=%b ld_valid=%b exp 1 0", op_done, ld_valid);
                end
            end
        end
        n_checks++;
        if (wr_cnt !== 1 || busy_cnt !== 2) begin
            n_fail++; $display("FAIL sw_counts: writes=%0d busy=%0d exp 1 2", wr_cnt, busy_cnt);
        end
        n_checks++;
        if (dm_mem[8'h20] !== 16'hBEEF) begin
            n_fail++; $display("FAIL sw_mem: got %h exp BEEF", dm_mem[8'h20]);
        end
        issue(3'd1, 8'h20, 16'h0, 8'h0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ld_valid !== 1'b1 || ld_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL sw_readback: ld_valid=%b ld_data=%h exp 1 BEEF", ld_valid, ld_data);
        end
        @(negedge clk);
    endtask

    task automatic test_lm;
        logic [2:0]  exp_idx [4];
        exp_idx = '{3'd0, 3'd2, 3'd5, 3'd7};
        for (int i = 0; i < 8; i++) rf_poke(3'(i), 16'hFFFF);
        for (int i = 0; i < 4; i++) dm_poke(8'h40 + 8'(i), 16'(i + 1));
        @(negedge clk);
        issue(3'd3, 8'h40, 16'h0, 8'hA5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dm_read, rf_we, dm_write, op_done} !== 4'b1100 || rf_waddr !== exp_idx[k] ||
                dm_addr !== 8'h40 + 8'(k) || rf_wdata !== 16'(k + 1)) begin
                n_fail++; $display("FAIL lm_access%0d: rd=%b we=%b waddr=%0d addr=%h wdata=%h exp 1 1 %0d %h %h",
                                   k, dm_read, rf_we, rf_waddr, dm_addr, rf_wdata,
                                   exp_idx[k], 8'h40 + 8'(k), 16'(k + 1));
            end
        end
        @(negedge clk);
        n_checks++;
        if (op_done !== 1'b1 || rf_we !== 1'b0 || dm_read !== 1'b0 || ld_valid !== 1'b0) begin
            n_fail++; $display("FAIL lm_done: op_done=%b we=%b rd=%b ld_valid=%b exp 1 0 0 0",
                               op_done, rf_we, dm_read, ld_valid);
        end
        n_checks++;
        if (rf_mem[0] !== 16'd1 || rf_mem[2] !== 16'd2 || rf_mem[5] !== 16'd3 || rf_mem[7] !== 16'd4 ||
            rf_mem[1] !== 16'hFFFF || rf_mem[6] !== 16'hFFFF) begin
            n_fail++; $display("FAIL lm_rf: R0=%h R1=%h R2=%h R5=%h R6=%h R7=%h exp 1 FFFF 2 3 FFFF 4",
                               rf_mem[0], rf_mem[1], rf_mem[2], rf_mem[5], rf_mem[6], rf_mem[7]);
        end
        @(negedge clk);
    endtask

    task automatic test_sm_wrap;
        logic [7:0]  exp_addr [3];
        logic [15:0] exp_data [3];
        int wr_cnt;
        exp_addr = '{8'hFE, 8'hFF, 8'h00};
        exp_data = '{16'h000A, 16'h000B, 16'h000C};
        wr_cnt = 0;
        rf_poke(3'd0, 16'h000A);
        rf_poke(3'd1, 16'h000B);
        rf_poke(3'd2, 16'h000C);
        rf_poke(3'd3, 16'h0DDD);
        dm_poke(8'hFD, 16'h5555);
        dm_poke(8'h01, 16'h6666);
        dm_poke(8'hFE, 16'h0);
        dm_poke(8'hFF, 16'h0);
        dm_poke(8'h00, 16'h0);
        @(negedge clk);
        issue(3'd4, 8'hFE, 16'h0, 8'h07);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (dm_write === 1'b1) wr_cnt++;
            if (k < 3) begin
                n_checks++;
                if (dm_write !== 1'b1 || dm_read !== 1'b0 || rf_we !== 1'b0 || rf_raddr !== 3'(k) ||
                    dm_addr !== exp_addr[k] || dm_wdata !== exp_data[k]) begin
                    n_fail++; $display("FAIL sm_access%0d: wr=%b rd=%b raddr=%0d addr=%h wdata=%h exp 1 0 %0d %h %h",
                                       k, dm_write, dm_read, rf_raddr, dm_addr, dm_wdata,
                                       k, exp_addr[k], exp_data[k]);
                end
            end else begin
                n_checks++;
                if (op_done !== 1'b1) begin
                    n_fail++; $display("FAIL sm_done: op_done=%b exp 1", op_done);
                end
            end
        end
        n_checks++;
        if (wr_cnt !== 3) begin
            n_fail++; $display("FAIL sm_count: writes=%0d exp 3", wr_cnt);
        end
        n_checks++;
        if (dm_mem[8'hFE] !== 16'h000A || dm_mem[8'hFF] !== 16'h000B || dm_mem[8'h00] !== 16'h000C ||
            dm_mem[8'hFD] !== 16'h5555 || dm_mem[8'h01] !== 16'h6666) begin
            n_fail++; $display("FAIL sm_mem: FD=%h FE=%h FF=%h 00=%h 01=%h exp 5555 A B C 6666",
                               dm_mem[8'hFD], dm_mem[8'hFE], dm_mem[8'hFF], dm_mem[8'h00], dm_mem[8'h01]);
        end
        @(negedge clk);
    endtask

    task automatic test_lm_zero;
        int rd_cnt;
        rd_cnt = 0;
        req_valid = 1'b1; req_op = 3'd3; req_addr = 8'h30; req_wdata = 16'h0; req_mask = 8'h00;
        @(posedge clk); #1;
        $display("tx op=3 addr=30 wdata=0000 mask=00 (second LW held valid)");
        // Hold a second request (LW) valid while the first op is busy.
        req_op = 3'd1; req_addr = 8'h10;
        @(negedge clk);
        n_checks++;
        if ({op_done, busy, req_ready, dm_read, rf_we, dm_write} !== 6'b110000) begin
            n_fail++; $display("FAIL lmz_done: done=%b busy=%b ready=%b rd=%b we=%b wr=%b exp 1 1 0 0 0 0",
                               op_done, busy, req_ready, dm_read, rf_we, dm_write);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || dm_read !== 1'b0) begin
            n_fail++; $display("FAIL lmz_not_accepted: busy=%b ready=%b rd=%b exp 0 1 0",
                               busy, req_ready, dm_read);
        end
        req_valid = 1'b0; req_op = 3'd0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (dm_read === 1'b1 || rf_we === 1'b1 || busy === 1'b1) rd_cnt++;
        end
        n_checks++;
        if (rd_cnt !== 0) begin
            n_fail++; $display("FAIL lmz_quiet: active cycles=%0d exp 0", rd_cnt);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8; i++) rf_poke(3'(i), 16'hEEEE);
        for (int i = 0; i < 8; i++) dm_poke(8'h50 + 8'(i), 16'h0100 + 16'(i));
        @(negedge clk);
        issue(3'd3, 8'h50, 16'h0, 8'hFF);
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 3'd0 || dm_addr !== 8'h50) begin
            n_fail++; $display("FAIL rst_first: we=%b waddr=%0d addr=%h exp 1 0 50", rf_we, rf_waddr, dm_addr);
        end
        @(posedge clk); #2;
        n_checks++;
        if (rf_waddr !== 3'd1 || dm_addr !== 8'h51) begin
            n_fail++; $display("FAIL rst_second: waddr=%0d addr=%h exp 1 51", rf_waddr, dm_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dm_read, dm_write, rf_we, busy, op_done, ld_valid} !== 6'b0 || req_ready !== 1'b1 ||
            ld_data !== 16'h0) begin
            n_fail++; $display("FAIL rst_abort: rd=%b wr=%b we=%b busy=%b ready=%b ld=%h exp 0 0 0 0 1 0",
                               dm_read, dm_write, rf_we, busy, req_ready, ld_data);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rf_mem[0] !== 16'h0100 || rf_mem[1] !== 16'hEEEE || rf_mem[2] !== 16'hEEEE) begin
            n_fail++; $display("FAIL rst_rf: R0=%h R1=%h R2=%h exp 0100 EEEE EEEE",
                               rf_mem[0], rf_mem[1], rf_mem[2]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL rst_release: ready=%b busy=%b we=%b exp 1 0 0", req_ready, busy, rf_we);
        end
        issue(3'd1, 8'h10, 16'h0, 8'h0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ld_valid !== 1'b1 || op_done !== 1'b1 || ld_data !== 16'h1234) begin
            n_fail++; $display("FAIL rst_lw: ld_valid=%b op_done=%b ld_data=%h exp 1 1 1234",
                               ld_valid, op_done, ld_data);
        end
        n_checks++;
        if (rf_mem[3] !== 16'hEEEE) begin
            n_fail++; $display("FAIL rst_rf_after: R3=%h exp EEEE", rf_mem[3]);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_addr   = 8'h0;
        req_wdata  = 16'h0;
        req_mask   = 8'h0;
        tb_dm_we   = 1'b0;
        tb_dm_addr = 8'h0;
        tb_dm_data = 16'h0;
        tb_rf_we   = 1'b0;
        tb_rf_addr = 3'd0;
        tb_rf_data = 16'h0;
        rst_n      = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_lm();
        test_sm_wrap();
        test_lm_zero();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator side of the data-memory port in the 6-stage pipelined RISC. Sits in the MEM stage, between the execute-stage pipeline register and the data memory.
- Turns single load/store requests (LW/SW) and multi-register requests (LM/SM, 8-bit register mask) into a cycle-by-cycle sequence of DM read/write strobes.
- Moves data to and from the register file and stalls the pipeline while busy.

Parameters:
- AW, 8, data-memory address width (256 words).
- DW, 16, data word width.
- NREG, 8, register count; register-mask width; register index is log2(NREG) bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from the EX/MEM register.
- req_ready  out  1  high when a request can be accepted.
- req_op  in  3  0=NONE, 1=LW, 2=SW, 3=LM, 4=SM; others are treated as NONE.
- req_addr  in  AW  base/effective address.
- req_wdata  in  DW  store data for SW.
- req_mask  in  NREG  register mask for LM/SM; bit i selects Ri.
- busy  out  1  pipeline stall = not IDLE.
- dm_addr  out  AW  DM address.
- dm_read  out  1  DM read enable.
- dm_write  out  1  DM write enable; DM writes at the rising edge.
- dm_wdata  out  DW  DM write data.
- dm_rdata  in  DW  DM read data; combinational from dm_addr while dm_read=1.
- rf_raddr  out  log2(NREG)  register-file read index for SM.
- rf_rdata  in  DW  register-file read data (combinational).
- rf_we  out  1  register-file write enable for LM.
- rf_waddr  out  log2(NREG)  register-file write index.
- rf_wdata  out  DW  register-file write data.
- ld_valid  out  1  one-cycle pulse; ld_data holds the LW result.
- ld_data  out  DW  registered LW data.
- op_done  out  1  one-cycle pulse at the end of any accepted op.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - All other outputs 0: busy, dm_read, dm_write, rf_we, ld_valid, op_done, dm_addr, dm_wdata, rf_*, ld_data.
  - Reset mid-operation aborts immediately; DM/RF writes already committed at earlier edges persist; no further strobes.
- States: IDLE, SINGLE, MULTI, DONE.
- Strobe defaults: dm_read, dm_write and rf_we are 0 in every state unless stated. dm_read is never high together with dm_write.
- IDLE:
  - req_ready=1.
  - Accept on a rising edge when req_valid=1 and op!=NONE. Latch op, addr, wdata and mask.
  - LW/SW go to SINGLE. LM/SM with mask!=0 go to MULTI. LM/SM with mask==0 go to DONE.
  - req_valid with op NONE is ignored.
- SINGLE (exactly 1 cycle), dm_addr=latched addr:
  - LW: dm_read=1; ld_data<=dm_rdata at the end of the cycle.
  - SW: dm_write=1, dm_wdata=latched wdata.
  - Next state DONE.
- MULTI (one access per cycle; cycles = popcount(mask)):
  - Current register i = lowest set bit of the remaining mask; zero bits are skipped in zero cycles.
  - dm_addr = base + k, where k is the access count so far, starting at 0. Arithmetic is modulo 2^AW (0xFF+1 wraps to 0x00).
  - LM: dm_read=1, rf_we=1, rf_waddr=i, rf_wdata=dm_rdata; the register is written at that edge.
  - SM: rf_raddr=i, dm_write=1, dm_wdata=rf_rdata.
  - At the end of each cycle, clear bit i and increment k. When the remaining mask becomes 0, go to DONE.
- DONE (1 cycle):
  - op_done=1; ld_valid=1 only if op was LW.
  - Next state IDLE; ld_data holds its value until the next LW.
- busy=1 in SINGLE, MULTI and DONE. req_valid in those states is ignored; the upstream holds it.
- Latency from the accept edge:
  - LW: ld_valid at cycle 2.
  - SW: write at the edge ending cycle 1; op_done at cycle 2.
  - LM/SM: op_done at cycle popcount+1; a zero mask gives op_done at cycle 1.
- Back-to-back operation: a new request can be accepted on the edge leaving DONE only if the state is IDLE at that edge. This gives at least 1 idle cycle between ops (req_ready=1).

Decomposition:
- Shared package dm_pkg:
  - op encodings (OP_NONE..OP_SM);
  - state encodings;
  - AW/DW/NREG defaults.
- One sub-module, mask_pri_enc: combinational lowest-set-bit priority encoder (NREG -> index plus a "none" flag), used for MULTI sequencing.

Test Plan:
- LW at 0x10, DM[0x10]=0x1234:
  - dm_read=1, dm_addr=0x10 for exactly 1 cycle;
  - ld_valid=1 with ld_data=0x1234 one cycle later;
  - op_done coincident with ld_valid.
- SW 0xBEEF to 0x20:
  - exactly one dm_write cycle, addr 0x20;
  - read-back by a following LW returns 0xBEEF;
  - busy high for 2 cycles.
- LM base 0x40, mask 0xA5 (R0, R2, R5, R7), DM[0x40..0x43]=1,2,3,4:
  - 4 access cycles with rf_waddr 0, 2, 5, 7 receiving 1, 2, 3, 4;
  - op_done follows the last access.
- SM base 0xFE, mask 0x07, R0..R2=0xA, 0xB, 0xC:
  - DM[0xFE]=0xA, DM[0xFF]=0xB, DM[0x00]=0xC (address wrap);
  - no other DM writes.
- LM mask 0x00:
  - no dm_read and no rf_we;
  - op_done 1 cycle after accept; a second req_valid during busy is not accepted.
- rst_n asserted low during the 2nd access of LM mask 0xFF:
  - all strobes 0 immediately, state IDLE, only R0 written;
  - after release, req_ready=1 and a new LW completes normally.
